// File: rtl/rxshift_pkg.sv
// rxshift_pkg: shared definitions for the rxshift UART receiver.
//   - rx_state_e  : receiver FSM state encoding
//   - BAUD_MIN    : smallest clocks-per-bit value that starts a frame
//   - DATA_W      : data bits per frame (fixed at 8)
//   - even_parity : parity bit value that makes the ones count even
package rxshift_pkg;

    localparam int         DATA_W   = 8;
    localparam logic [7:0] BAUD_MIN = 8'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_e;

    // The even-parity bit equals the XOR of the data bits.
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/rxshift_if.sv
// rxshift_if: groups the rxshift configuration, serial line and result
// signals. The receiver uses the slave modport; whatever drives the line
// and consumes bytes uses the master modport.
//   i_Baud       clocks per bit (4..255)
//   i_Enable     receiver enable
//   i_Rx_Serial  asynchronous serial line, idles high
//   o_Rx_Data    last received byte
//   o_Rx_Valid   one-cycle good-byte pulse
//   o_Frame_Err  one-cycle stop-bit-low pulse
//   o_Parity_Err one-cycle parity mismatch pulse
//   o_Busy       receiver not idle
interface rxshift_if;
    logic [7:0] i_Baud;
    logic       i_Enable;
    logic       i_Rx_Serial;
    logic [7:0] o_Rx_Data;
    logic       o_Rx_Valid;
    logic       o_Frame_Err;
    logic       o_Parity_Err;
    logic       o_Busy;

    modport slave (
        input  i_Baud, i_Enable, i_Rx_Serial,
        output o_Rx_Data, o_Rx_Valid, o_Frame_Err, o_Parity_Err, o_Busy
    );

    modport master (
        output i_Baud, i_Enable, i_Rx_Serial,
        input  o_Rx_Data, o_Rx_Valid, o_Frame_Err, o_Parity_Err, o_Busy
    );
endinterface

// File: rtl/rxshift_rx_sync.sv
// rx_sync: SYNC_STAGES-deep flop chain bringing the asynchronous serial
// line into the i_Pclk domain. All stages reset to 1 (line idle level) so
// a reset never looks like a start bit.
//   i_Pclk   clock
//   i_Reset  synchronous active-high reset
//   i_Async  asynchronous input
//   o_Sync   synchronized output
module rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_Pclk,
    input  logic i_Reset,
    input  logic i_Async,
    output logic o_Sync
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift the raw line into the low end of the chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_Async};
    end

    // Synchronizer flops, reset to the idle-high level.
    always_ff @(posedge i_Pclk) begin
        if (i_Reset) begin
            sync_q <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_Sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rxshift.sv
// rxshift: UART serial receiver, oversampling at i_Baud clocks per bit.
// Recovers 8N1 frames LSB first (8E1 when RXSHIFT_PARITY_EN is defined)
// and reports each byte with a one-cycle valid or error pulse.
//   i_Pclk   peripheral clock, rising edge
//   i_Reset  synchronous active-high reset
//   bus      rxshift_if.slave: i_Baud, i_Enable, i_Rx_Serial in;
//            o_Rx_Data, o_Rx_Valid, o_Frame_Err, o_Parity_Err, o_Busy out
// Build option: define RXSHIFT_PARITY_EN for an even parity bit between
// the data and the stop bit; otherwise o_Parity_Err is tied low.
module rxshift
    import rxshift_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_Pclk,
    input  logic       i_Reset,
    rxshift_if.slave   bus
);

    logic rx_s;

    rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rx_sync (
        .i_Pclk  (i_Pclk),
        .i_Reset (i_Reset),
        .i_Async (bus.i_Rx_Serial),
        .o_Sync  (rx_s)
    );

    rx_state_e         state_q,   state_d;
    logic [7:0]        cnt_q,     cnt_d;
    logic [7:0]        baud_q,    baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q,   shift_d;
    logic [DATA_W-1:0] data_q,    data_d;
    logic              valid_q,   valid_d;
    logic              ferr_q,    ferr_d;
    logic              busy_q,    busy_d;
`ifdef RXSHIFT_PARITY_EN
    logic              par_err_q, par_err_d;
    logic              perr_q,    perr_d;
`endif

    // Next-state logic: bit timing, sampling, and result pulses.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef RXSHIFT_PARITY_EN
        par_err_d = par_err_q;
        perr_d    = 1'b0;
`endif
        if (!bus.i_Enable) begin
            // Abandon any frame; o_Rx_Data keeps its last value.
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s && (bus.i_Baud >= BAUD_MIN)) begin
                        baud_d  = bus.i_Baud;
                        cnt_d   = 8'd0;
                        state_d = ST_START;
                    end else begin
                        cnt_d = 8'd0;
                    end
                end
                ST_START: begin
                    // Mid-start check rejects short low glitches.
                    if (cnt_q == (baud_q >> 1)) begin
                        if (rx_s) begin
                            state_d = ST_IDLE;
                            cnt_d   = 8'd0;
                        end else begin
                            cnt_d     = 8'd0;
                            bit_idx_d = 3'd0;
                            state_d   = ST_DATA;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_DATA: begin
                    // Counter restarted mid-start, so N-1 lands mid-bit.
                    if (cnt_q == (baud_q - 8'd1)) begin
                        cnt_d     = 8'd0;
                        shift_d   = {rx_s, shift_q[DATA_W-1:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef RXSHIFT_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
`ifdef RXSHIFT_PARITY_EN
                ST_PARITY: begin
                    if (cnt_q == (baud_q - 8'd1)) begin
                        cnt_d     = 8'd0;
                        par_err_d = (rx_s != even_parity(shift_q));
                        state_d   = ST_STOP;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt_q == (baud_q - 8'd1)) begin
                        cnt_d  = 8'd0;
                        data_d = shift_q;
                        if (rx_s) begin
                            state_d = ST_IDLE;
`ifdef RXSHIFT_PARITY_EN
                            if (par_err_q) begin
                                perr_d = 1'b1;
                            end else begin
                                valid_d = 1'b1;
                            end
`else
                            valid_d = 1'b1;
`endif
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_WAIT_HIGH: begin
                    // A held-low line (break) yields only one frame error.
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_HIGH;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
        // Busy is registered from the next state so it tracks state_q.
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_Pclk) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            baud_q    <= 8'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= {DATA_W{1'b0}};
            data_q    <= {DATA_W{1'b0}};
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef RXSHIFT_PARITY_EN
            par_err_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
`ifdef RXSHIFT_PARITY_EN
            par_err_q <= par_err_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign bus.o_Rx_Data   = data_q;
    assign bus.o_Rx_Valid  = valid_q;
    assign bus.o_Frame_Err = ferr_q;
    assign bus.o_Busy      = busy_q;
`ifdef RXSHIFT_PARITY_EN
    assign bus.o_Parity_Err = perr_q;
`else
    assign bus.o_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_rxshift.sv
// tb_rxshift: directed frames for rxshift. Stimulus pushes the expected
// pulse (kind, byte, absolute cycle) into a queue; a monitor pops and
// compares whenever a pulse appears and checks o_Rx_Data holds otherwise.
// Cycle numbers count rising edges; the edge that first captures the low
// start bit is edge 0 of that frame.
module tb_rxshift;

    localparam logic [2:0] K_VALID = 3'b001;
    localparam logic [2:0] K_FERR  = 3'b010;
    localparam logic [2:0] K_PERR  = 3'b100;

`ifdef RXSHIFT_PARITY_EN
    localparam int LAT87 = 916;
    localparam int LAT4  = 45;
    localparam int EXTRA = 1;
`else
    localparam int LAT87 = 829;
    localparam int LAT4  = 41;
    localparam int EXTRA = 0;
`endif

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   s;
    exp_t exp_q[$];

    rxshift_if bus();

    rxshift #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .i_Pclk  (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input logic [2:0] kind, input logic [7:0] data, input int at);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"},  {24'd0, bus.o_Rx_Data}, 32'h00);
        chk({tag, "_valid"}, {31'd0, bus.o_Rx_Valid}, 32'd0);
        chk({tag, "_ferr"},  {31'd0, bus.o_Frame_Err}, 32'd0);
        chk({tag, "_perr"},  {31'd0, bus.o_Parity_Err}, 32'd0);
        chk({tag, "_busy"},  {31'd0, bus.o_Busy}, 32'd0);
    endtask

    // Drives one frame starting at the current falling edge. abort_bit in
    // 0..7 asserts i_Reset halfway through that data bit instead.
    task automatic send_frame(input logic [7:0] d, input int n, input logic par,
                              input logic stop_v, input int stop_len, input int abort_bit);
        bus.i_Rx_Serial = 1'b0;
        repeat (n) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.i_Rx_Serial = d[i];
            if (i == abort_bit) begin
                repeat (n / 2) @(negedge clk);
                rst = 1'b1;
                repeat (3) @(negedge clk);
                chk_reset_outputs("abort_reset");
                rst = 1'b0;
                bus.i_Rx_Serial = 1'b1;
                return;
            end
            repeat (n) @(negedge clk);
        end
        if (EXTRA == 1) begin
            bus.i_Rx_Serial = par;
            repeat (n) @(negedge clk);
        end
        bus.i_Rx_Serial = stop_v;
        repeat (stop_len) @(negedge clk);
        bus.i_Rx_Serial = 1'b1;
    endtask

    // Scoreboard monitor.
    initial begin
        logic [2:0] pulses;
        logic [7:0] prev_data;
        exp_t       e;
        prev_data = 8'h00;
        forever begin
            @(negedge clk);
            pulses = {bus.o_Parity_Err, bus.o_Frame_Err, bus.o_Rx_Valid};
            if (pulses != 3'b000) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse actual=%b required=none data=%0h cycle=%0d",
                             pulses, bus.o_Rx_Data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind",  {29'd0, pulses}, {29'd0, e.kind});
                    chk("pulse_data",  {24'd0, bus.o_Rx_Data}, {24'd0, e.data});
                    chk("pulse_cycle", cyc, e.cyc);
                end
            end else if (!rst) begin
                chk("data_hold", {24'd0, bus.o_Rx_Data}, {24'd0, prev_data});
            end
            prev_data = bus.o_Rx_Data;
        end
    end

    // Watchdog.
    initial begin
        #600000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    // Directed stimulus.
    initial begin
        rst = 1'b1;
        bus.i_Enable    = 1'b1;
        bus.i_Baud      = 8'd87;
        bus.i_Rx_Serial = 1'b1;
        repeat (4) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single frame 0x8A at N=87.
        s = cyc + 1;
        push_exp(K_VALID, 8'h8A, s + LAT87);
        send_frame(8'h8A, 87, 1'b1, 1'b1, 87, -1);
        repeat (20) @(negedge clk);

        // Back-to-back 0x51, 0xFF with no idle gap.
        s = cyc + 1;
        push_exp(K_VALID, 8'h51, s + LAT87);
        send_frame(8'h51, 87, 1'b1, 1'b1, 87, -1);
        push_exp(K_VALID, 8'hFF, s + LAT87 + (10 + EXTRA) * 87);
        send_frame(8'hFF, 87, 1'b0, 1'b1, 87, -1);
        repeat (20) @(negedge clk);

        // 20-cycle low glitch: busy until the mid-start sample, no pulse.
        s = cyc + 1;
        bus.i_Rx_Serial = 1'b0;
        repeat (20) @(negedge clk);
        bus.i_Rx_Serial = 1'b1;
        wait_to(s + 45);
        chk("glitch_busy_before", {31'd0, bus.o_Busy}, 32'd1);
        wait_to(s + 46);
        chk("glitch_busy_after", {31'd0, bus.o_Busy}, 32'd0);
        repeat (20) @(negedge clk);

        // Frame 0x3C with stop held low for 300 cycles.
        s = cyc + 1;
        push_exp(K_FERR, 8'h3C, s + LAT87);
        send_frame(8'h3C, 87, 1'b0, 1'b0, 300, -1);
        wait_to(s + 1084 + EXTRA * 87);
        chk("break_busy_held", {31'd0, bus.o_Busy}, 32'd1);
        wait_to(s + 1086 + EXTRA * 87);
        chk("break_busy_released", {31'd0, bus.o_Busy}, 32'd0);
        repeat (20) @(negedge clk);

        // Reset during data bit 4, then a clean 0xA5.
        send_frame(8'h5A, 87, 1'b0, 1'b1, 87, 4);
        repeat (10) @(negedge clk);
        s = cyc + 1;
        push_exp(K_VALID, 8'hA5, s + LAT87);
        send_frame(8'hA5, 87, 1'b0, 1'b1, 87, -1);
        repeat (20) @(negedge clk);

        // Enable dropped mid-frame: frame discarded, no pulse.
        bus.i_Rx_Serial = 1'b0;
        repeat (150) @(negedge clk);
        chk("enable_busy_mid", {31'd0, bus.o_Busy}, 32'd1);
        bus.i_Enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("enable_busy_off", {31'd0, bus.o_Busy}, 32'd0);
        bus.i_Rx_Serial = 1'b1;
        repeat (5) @(negedge clk);
        bus.i_Enable = 1'b1;
        repeat (5) @(negedge clk);
        chk("enable_busy_idle", {31'd0, bus.o_Busy}, 32'd0);

        // i_Baud below the minimum never starts a frame.
        bus.i_Baud = 8'd3;
        bus.i_Rx_Serial = 1'b0;
        repeat (10) @(negedge clk);
        chk("baud3_busy", {31'd0, bus.o_Busy}, 32'd0);
        bus.i_Rx_Serial = 1'b1;
        repeat (5) @(negedge clk);

        // Minimum N=4, frame 0xC3.
        bus.i_Baud = 8'd4;
        s = cyc + 1;
        push_exp(K_VALID, 8'hC3, s + LAT4);
        send_frame(8'hC3, 4, 1'b0, 1'b1, 4, -1);
        repeat (10) @(negedge clk);
        bus.i_Baud = 8'd87;

`ifdef RXSHIFT_PARITY_EN
        // 0x07 has three ones: parity bit 0 is wrong, 1 is right.
        s = cyc + 1;
        push_exp(K_PERR, 8'h07, s + LAT87);
        send_frame(8'h07, 87, 1'b0, 1'b1, 87, -1);
        repeat (10) @(negedge clk);
        s = cyc + 1;
        push_exp(K_VALID, 8'h07, s + LAT87);
        send_frame(8'h07, 87, 1'b1, 1'b1, 87, -1);
        repeat (10) @(negedge clk);
`endif

        repeat (50) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
